axi3_mst_read_engine: RTL and testbench

AXI3 read-channel master for the DMA/CRC datapath. On a start pulse it reads `data_len` 32-bit words from `addr_src` as a sequence of INCR bursts, with one burst outstanding at a time. Each accepted beat is forwarded to a downstream FIFO via `read_data`/`en_write`. FIFO backpressure (`fifo_full`) throttles `rready`.

---
 rtl/axi3_pkg.sv | 25 ++
 rtl/axi3_burst_len_calc.sv | 31 +++
 rtl/axi3_mst_read_engine.sv | 202 ++++++++++++++++++++
 tb/tb_axi3_mst_read_engine.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi3_pkg.sv
// Shared AXI3 read-master definitions: fixed AR channel encodings, burst cap,
// read-engine state encoding and the 4 KB boundary helper.
package axi3_pkg;

  localparam int unsigned MAX_BEATS = 16;

  localparam logic [2:0] SIZE_4B       = 3'b010;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] LOCK_NORMAL   = 2'b00;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0000;
  localparam logic [2:0] PROT_DEFAULT  = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_state_e;

  // Number of 32-bit words from a word offset inside a 4 KB page to the page end.
  function automatic logic [10:0] words_to_4k(input logic [9:0] word_off);
    return 11'd1024 - {1'b0, word_off};
  endfunction

endpackage

// File: rtl/axi3_burst_len_calc.sv
// Burst sizing: beats = min(MAX_BEATS, remaining words, words left in the 4 KB page).
module axi3_burst_len_calc
  import axi3_pkg::*;
#(
  parameter int unsigned MAX_BEATS_P = axi3_pkg::MAX_BEATS
) (
  input  logic [31:0] addr,
  input  logic [15:0] remain,
  output logic [4:0]  beats,
  output logic [3:0]  arlen
);

  localparam logic [15:0] CAP = 16'(MAX_BEATS_P);

  logic [10:0] to_4k_s;
  logic [15:0] capped_s;
  logic [15:0] beats_w_s;
  logic        unused_s;

  assign to_4k_s   = words_to_4k(addr[11:2]);
  assign capped_s  = (remain < CAP) ? remain : CAP;
  assign beats_w_s = ({5'd0, to_4k_s} < capped_s) ? {5'd0, to_4k_s} : capped_s;

  // A 16-beat burst truncates to 4'd0 here, so the subtraction wraps to 15.
  assign beats = beats_w_s[4:0];
  assign arlen = beats_w_s[3:0] - 4'd1;

  // Page number, byte lane and upper count bits do not influence the length.
  assign unused_s = ^{addr[31:12], addr[1:0], beats_w_s[15:5]};

endmodule

// File: rtl/axi3_mst_read_engine.sv
// AXI3 read master: splits a word transfer into INCR bursts (one outstanding),
// forwards accepted beats to a FIFO and flags protocol/response errors.
// Optional build macro: AXI3_RD_ERR_ABORT_EN -- stop after the burst that saw an error.
module axi3_mst_read_engine
  import axi3_pkg::*;
#(
  parameter int unsigned MAX_BEATS = axi3_pkg::MAX_BEATS,
  parameter logic [3:0]  ID_VAL    = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_src,
  input  logic [15:0] data_len,
  input  logic        mst_begin,
  input  logic        fifo_full,
  output logic [31:0] read_data,
  output logic        en_write,
  output logic        error,
  input  logic        arready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  rd_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] remain_q, remain_d;
  logic [4:0]  beat_cnt_q, beat_cnt_d;
  logic [4:0]  beats_q, beats_d;
  logic        arvalid_q, arvalid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [3:0]  arlen_q, arlen_d;
  logic        error_q, error_d;

  logic [31:0] next_addr_s;
  logic [15:0] remain_dec_s;
  logic [31:0] calc_addr_s;
  logic [15:0] calc_remain_s;
  logic [4:0]  calc_beats_s;
  logic [3:0]  calc_arlen_s;
  logic        rready_s;
  logic        beat_hs_s;
  logic        beat_err_s;
  logic        abort_s;

  // Address of the following burst and remaining count after the current beat.
  assign next_addr_s  = addr_q + {25'd0, beats_q, 2'b00};
  assign remain_dec_s = (remain_q != 16'd0) ? (remain_q - 16'd1) : 16'd0;

  // When idle the next burst is sized from the start request, otherwise from
  // the post-burst address and count, so arlen is ready the cycle ADDR is entered.
  assign calc_addr_s   = (state_q == IDLE) ? addr_src : next_addr_s;
  assign calc_remain_s = (state_q == IDLE) ? data_len : remain_dec_s;

  axi3_burst_len_calc #(
    .MAX_BEATS_P (MAX_BEATS)
  ) u_len_calc (
    .addr   (calc_addr_s),
    .remain (calc_remain_s),
    .beats  (calc_beats_s),
    .arlen  (calc_arlen_s)
  );

  assign rready_s  = (state_q == DATA) && !fifo_full;
  assign beat_hs_s = rvalid && rready_s;

  // Classify the current beat and decide whether an error ends the transfer.
  always_comb begin
    beat_err_s = 1'b0;
    abort_s    = 1'b0;
    if ((rresp != RESP_OKAY) || (rid != ID_VAL)) begin
      beat_err_s = 1'b1;
    end else if (rlast && (beat_cnt_q > 5'd1)) begin
      beat_err_s = 1'b1;
    end else if (!rlast && (beat_cnt_q == 5'd1)) begin
      beat_err_s = 1'b1;
    end else begin
      beat_err_s = 1'b0;
    end
`ifdef AXI3_RD_ERR_ABORT_EN
    abort_s = error_q || beat_err_s;
`else
    abort_s = 1'b0;
`endif
  end

  // Next-state and register-update logic for the IDLE/ADDR/DATA sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    beat_cnt_d = beat_cnt_q;
    beats_d    = beats_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    error_d    = error_q;
    case (state_q)
      IDLE: begin
        if (mst_begin && (data_len != 16'd0)) begin
          addr_d    = addr_src;
          remain_d  = data_len;
          error_d   = 1'b0;
          arvalid_d = 1'b1;
          araddr_d  = addr_src;
          arlen_d   = calc_arlen_s;
          beats_d   = calc_beats_s;
          state_d   = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (arready) begin
          arvalid_d  = 1'b0;
          beat_cnt_d = beats_q;
          state_d    = DATA;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      DATA: begin
        if (beat_hs_s) begin
          remain_d   = remain_dec_s;
          beat_cnt_d = (beat_cnt_q != 5'd0) ? (beat_cnt_q - 5'd1) : 5'd0;
          error_d    = error_q || beat_err_s;
          if (rlast) begin
            addr_d = next_addr_s;
            if ((remain_dec_s == 16'd0) || abort_s) begin
              state_d = IDLE;
            end else begin
              arvalid_d = 1'b1;
              araddr_d  = next_addr_s;
              arlen_d   = calc_arlen_s;
              beats_d   = calc_beats_s;
              state_d   = ADDR;
            end
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      remain_q   <= 16'd0;
      beat_cnt_q <= 5'd0;
      beats_q    <= 5'd0;
      arvalid_q  <= 1'b0;
      araddr_q   <= 32'd0;
      arlen_q    <= 4'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      beat_cnt_q <= beat_cnt_d;
      beats_q    <= beats_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      error_q    <= error_d;
    end
  end

  assign arid      = ID_VAL;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsize    = SIZE_4B;
  assign arburst   = BURST_INCR;
  assign arlock    = LOCK_NORMAL;
  assign arcache   = CACHE_DEFAULT;
  assign arprot    = PROT_DEFAULT;
  assign arvalid   = arvalid_q;
  assign rready    = rready_s;
  assign read_data = rdata;
  assign en_write  = beat_hs_s;
  assign error     = error_q;

endmodule

// File: tb/tb_axi3_mst_read_engine.sv
// Self-checking bench for axi3_mst_read_engine: randomized AXI slave + FIFO,
// expected bursts/data derived from address arithmetic on the transfer request.
module tb_axi3_mst_read_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr_src;
  logic [15:0] data_len;
  logic        mst_begin;
  logic        fifo_full;
  logic [31:0] read_data;
  logic        en_write;
  logic        error;
  logic        arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  axi3_mst_read_engine dut (
    .clk(clk), .rst_n(rst_n), .addr_src(addr_src), .data_len(data_len),
    .mst_begin(mst_begin), .fifo_full(fifo_full), .read_data(read_data),
    .en_write(en_write), .error(error), .arready(arready), .arid(arid),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

`ifdef AXI3_RD_ERR_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [35:0] ar_q[$];   // observed {araddr, arlen}
  logic [35:0] exp_ar[$];
  logic [31:0] wr_q[$];
  logic [31:0] exp_wr[$];

  logic [31:0] salt;
  int ar_mode, fifo_mode, rv_pct;
  int inj_kind, inj_burst, inj_beat;
  int en_viol = 0, bp_viol = 0, junk_viol = 0, ar_viol = 0, ff_rv_cnt = 0;
  int pulse_cnt = 0;
  bit pulse_done = 1'b0;

  bit          r_act = 1'b0;
  bit          junk = 1'b0;
  int          b_idx, b_beats, k, ar_wait;
  logic [31:0] b_addr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected bursts: each burst is min(16, remaining, words to the 4 KB page end).
  function automatic void build_exp(input logic [31:0] a0, input int len, input int stop_after);
    logic [31:0] a = a0;
    int rem = len;
    int n = 0;
    int b;
    exp_ar.delete();
    exp_wr.delete();
    while (rem > 0 && (stop_after < 0 || n <= stop_after)) begin
      b = 16;
      if (rem < b) b = rem;
      if (int'((32'd4096 - (a % 32'd4096)) / 32'd4) < b) b = int'((32'd4096 - (a % 32'd4096)) / 32'd4);
      exp_ar.push_back({a, 4'(b - 1)});
      for (int i = 0; i < b; i++) exp_wr.push_back(mem(a + 32'(4 * i)));
      a = a + 32'(4 * b);
      rem = rem - b;
      n++;
    end
  endfunction

  // Monitor (negedge) and AXI slave / FIFO model (posedge + 1).
  initial begin : slave
    logic s_ar_hs, s_r_hs, arv_wait;
    logic [31:0] s_araddr, w_addr;
    logic [3:0]  s_arlen, w_len;
    int last_k;
    arv_wait = 1'b0; w_addr = 32'd0; w_len = 4'd0; k = 0; ar_wait = 0;
    b_idx = 0; b_beats = 0; b_addr = 32'd0;
    forever begin
      @(negedge clk);
      s_ar_hs = arvalid & arready;
      s_r_hs  = rvalid & rready;
      s_araddr = araddr;
      s_arlen  = arlen;
      if (rst_n) begin
        if (s_ar_hs) ar_q.push_back({araddr, arlen});
        if (en_write) wr_q.push_back(read_data);
        if (en_write !== (rvalid & rready)) en_viol++;
        if (en_write && (read_data !== rdata)) en_viol++;
        if (fifo_full && rready) bp_viol++;
        if (junk && rready) junk_viol++;
        if (fifo_full && rvalid) ff_rv_cnt++;
        if (arv_wait && (arvalid !== 1'b1 || araddr !== w_addr || arlen !== w_len)) ar_viol++;
        arv_wait = arvalid & ~arready;
        w_addr = araddr;
        w_len = arlen;
      end else begin
        arv_wait = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        arready = 1'b0; rvalid = 1'b0; fifo_full = 1'b0;
        r_act = 1'b0; junk = 1'b0; ar_wait = 0;
      end else begin
        if (s_r_hs && r_act) begin
          if (rlast) r_act = 1'b0;
          k++;
        end
        if (s_ar_hs) begin
          b_addr = s_araddr; b_beats = int'(s_arlen) + 1; b_idx = ar_q.size() - 1;
          k = 0; r_act = 1'b1; ar_wait = 0;
        end else if (arvalid) begin
          ar_wait++;
        end
        case (ar_mode)
          0: arready = 1'b1;
          1: arready = ($urandom_range(0, 1) == 1);
          default: arready = arvalid && (ar_wait > 3);
        endcase
        if (fifo_mode == 1) begin
          fifo_full = ($urandom_range(0, 3) == 0);
        end else if (fifo_mode == 2 && !pulse_done && wr_q.size() >= 5 && pulse_cnt < 2) begin
          fifo_full = 1'b1;
          pulse_cnt++;
        end else begin
          fifo_full = 1'b0;
          if (pulse_cnt >= 2) pulse_done = 1'b1;
        end
        if (rvalid && !s_r_hs && !junk) begin
          // beat offered but not taken: hold it stable
        end else if (r_act) begin
          junk = 1'b0;
          rvalid = ($urandom_range(0, 99) < rv_pct);
          last_k = b_beats - 1;
          if (inj_kind == 3 && b_idx == inj_burst) last_k = inj_beat;
          if (inj_kind == 4 && b_idx == inj_burst) last_k = b_beats;
          rlast = (k == last_k);
          rdata = mem(b_addr + 32'(4 * k));
          rresp = (inj_kind == 1 && b_idx == inj_burst && k == inj_beat) ? 2'b10 : 2'b00;
          rid   = (inj_kind == 2 && b_idx == inj_burst && k == inj_beat) ? 4'h5 : 4'h0;
        end else begin
          junk = ($urandom_range(0, 9) < 3);
          rvalid = junk;
          rdata = $urandom;
          rlast = 1'($urandom);
          rresp = 2'b00;
          rid = 4'h0;
        end
      end
    end
  end

  task automatic start(input logic [31:0] a, input logic [15:0] l);
    addr_src = a;
    data_len = l;
    mst_begin = 1'b1;
    @(posedge clk); #1;
    mst_begin = 1'b0;
  endtask

  task automatic setup(input int arm, input int ffm, input int rvp, input int ik, input int ib, input int ibt);
    ar_mode = arm; fifo_mode = ffm; rv_pct = rvp;
    inj_kind = ik; inj_burst = ib; inj_beat = ibt;
    salt = $urandom;
    ar_q.delete();
    wr_q.delete();
  endtask

  task automatic run_check(input string tag, input logic exp_err);
    bit done = 1'b0;
    int n;
    for (int c = 0; c < 8000; c++) begin
      if (wr_q.size() >= exp_wr.size() && !r_act && !arvalid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, ".done"}, 64'(done), 64'd1);
    repeat (30) begin @(posedge clk); #1; end
    chk({tag, ".ar_count"}, 64'(ar_q.size()), 64'(exp_ar.size()));
    n = (ar_q.size() < exp_ar.size()) ? ar_q.size() : exp_ar.size();
    for (int i = 0; i < n; i++) begin
      if (ar_q[i] !== exp_ar[i]) begin
        chk({tag, ".ar_addr_len"}, 64'(ar_q[i]), 64'(exp_ar[i]));
        break;
      end
    end
    chk({tag, ".wr_count"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    n = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
    for (int i = 0; i < n; i++) begin
      if (wr_q[i] !== exp_wr[i]) begin
        chk({tag, ".wr_data"}, 64'(wr_q[i]), 64'(exp_wr[i]));
        break;
      end
    end
    chk({tag, ".error"}, 64'(error), 64'(exp_err));
    chk({tag, ".viol"}, 64'(en_viol + bp_viol + junk_viol + ar_viol), 64'd0);
  endtask

  initial begin : main
    bit ok;
    int n0, w0;
    logic [31:0] a;
    rst_n = 1'b0; mst_begin = 1'b0; addr_src = 32'd0; data_len = 16'd0;
    fifo_full = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    rresp = 2'b00; rlast = 1'b0; rid = 4'h0;
    setup(0, 0, 100, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.arvalid", 64'(arvalid), 64'd0);
    chk("rst.rready", 64'(rready), 64'd0);
    chk("rst.en_write", 64'(en_write), 64'd0);
    chk("rst.error", 64'(error), 64'd0);
    chk("rst.araddr", 64'(araddr), 64'd0);
    chk("rst.arlen", 64'(arlen), 64'd0);
    chk("rst.fixed", 64'({arid, arsize, arburst, arlock, arcache, arprot}), 64'({4'h0, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    // Full-speed 333-word transfer from address 0.
    setup(0, 0, 100, 0, 0, 0);
    build_exp(32'h0, 333, -1);
    start(32'h0, 16'd333);
    run_check("len333", 1'b0);

    // 4 KB boundary split; arvalid on the cycle after mst_begin.
    setup(0, 0, 100, 0, 0, 0);
    build_exp(32'hFF8, 5, -1);
    start(32'hFF8, 16'd5);
    @(negedge clk);
    chk("ff8.arvalid_next", 64'(arvalid), 64'd1);
    chk("ff8.first_ar", 64'({araddr, arlen}), 64'({32'hFF8, 4'd1}));
    run_check("ff8", 1'b0);

    // arready held low for 3 cycles.
    setup(2, 0, 100, 0, 0, 0);
    build_exp(32'h0000_7000, 4, -1);
    start(32'h0000_7000, 16'd4);
    run_check("arready_hold", 1'b0);

    // Two-cycle FIFO full mid-burst with rvalid high.
    setup(0, 2, 100, 0, 0, 0);
    pulse_cnt = 0; pulse_done = 1'b0; ff_rv_cnt = 0;
    build_exp(32'h0000_A100, 20, -1);
    start(32'h0000_A100, 16'd20);
    run_check("fifo_pulse", 1'b0);
    chk("fifo_pulse.seen", 64'(ff_rv_cnt >= 2), 64'd1);

    // Randomized transfers near page ends with random backpressure.
    for (int t = 0; t < 4; t++) begin
      setup(1, 1, 70, 0, 0, 0);
      a = (32'($urandom_range(1, 15)) << 12) + (32'($urandom_range(960, 1023)) << 2);
      n0 = $urandom_range(1, 120);
      build_exp(a, n0, -1);
      start(a, 16'(n0));
      run_check($sformatf("rand%0d", t), 1'b0);
    end

    // SLVERR on beat 3 of burst 1.
    setup(0, 0, 100, 1, 0, 2);
    build_exp(32'h0000_8000, 48, ABORT ? 0 : -1);
    start(32'h0000_8000, 16'd48);
    run_check("rresp_err", 1'b1);

    // Wrong RID in burst 2; the new start must clear the sticky error.
    setup(1, 1, 80, 2, 1, 5);
    build_exp(32'h0000_B040, 40, ABORT ? 1 : -1);
    start(32'h0000_B040, 16'd40);
    chk("rid_err.err_cleared", 64'(error), 64'd0);
    run_check("rid_err", 1'b1);

    // Early rlast on beat 2 of a 4-beat burst: burst treated as complete.
    setup(0, 0, 100, 3, 0, 1);
    salt = 32'h1234_5678;
    exp_ar.delete(); exp_wr.delete();
    exp_ar.push_back({32'h2000, 4'd3});
    exp_wr.push_back(mem(32'h2000)); exp_wr.push_back(mem(32'h2004));
    if (!ABORT) begin
      exp_ar.push_back({32'h2010, 4'd1});
      exp_wr.push_back(mem(32'h2010)); exp_wr.push_back(mem(32'h2014));
    end
    start(32'h2000, 16'd4);
    run_check("early_rlast", 1'b1);

    // Missing rlast: one extra beat accepted and written.
    setup(0, 0, 100, 4, 0, 0);
    exp_ar.delete(); exp_wr.delete();
    exp_ar.push_back({32'h3000, 4'd3});
    for (int i = 0; i < 5; i++) exp_wr.push_back(mem(32'h3000 + 32'(4 * i)));
    start(32'h3000, 16'd4);
    run_check("missing_rlast", 1'b1);

    // Zero-length start is ignored.
    setup(0, 0, 100, 0, 0, 0);
    start(32'h4000, 16'd0);
    repeat (20) begin @(posedge clk); #1; end
    chk("len0.ar_count", 64'(ar_q.size()), 64'd0);
    chk("len0.wr_count", 64'(wr_q.size()), 64'd0);

    // mst_begin while busy: no relatch, no extra AR.
    setup(1, 1, 80, 0, 0, 0);
    build_exp(32'h0000_C000, 40, -1);
    start(32'h0000_C000, 16'd40);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (wr_q.size() >= 3) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("busy.reached", 64'(ok), 64'd1);
    start(32'h0000_5000, 16'd7);
    run_check("busy_begin", 1'b0);

    // Reset in DATA aborts the transfer.
    setup(0, 0, 100, 0, 0, 0);
    start(32'h0000_9000, 16'd64);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (wr_q.size() >= 10) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("rst_mid.reached", 64'(ok), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid.outputs", 64'({arvalid, rready, en_write, error, araddr, arlen}), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = ar_q.size();
    w0 = wr_q.size();
    repeat (30) begin @(posedge clk); #1; end
    chk("rst_mid.no_ar", 64'(ar_q.size()), 64'(n0));
    chk("rst_mid.no_wr", 64'(wr_q.size()), 64'(w0));

    // Clean transfer after reset.
    setup(1, 1, 70, 0, 0, 0);
    build_exp(32'h0000_DFC0, 30, -1);
    start(32'h0000_DFC0, 16'd30);
    run_check("post_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
